// File: rtl/csa_pipe_adder3.sv
// rtl/csa_pipe_adder3.sv - two-stage carry-save three-operand adder with valid/ready handshake
module csa_pipe_adder3 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH-1:0]   in_c,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH+1:0]   out_sum
);
    localparam int EW = WIDTH + 2;

    // Two guard bits make the three-operand sum exact in either signedness.
    function automatic logic [EW-1:0] ext(input logic [WIDTH-1:0] v, input logic sgn);
        return {{2{sgn & v[WIDTH-1]}}, v};
    endfunction

    logic [EW-1:0] ea, eb, ec;
    logic [EW-1:0] csa_sum, csa_maj;
    logic [EW-1:0] s1_sum, s1_carry;
    logic          s1_valid;
    logic          out_adv, s1_adv;

    always_comb begin
        ea      = ext(in_a, in_signed);
        eb      = ext(in_b, in_signed);
        ec      = ext(in_c, in_signed);
        csa_sum = ea ^ eb ^ ec;
        csa_maj = (ea & eb) | (ea & ec) | (eb & ec);
    end

    assign out_adv  = !out_valid | out_ready;
    assign s1_adv   = !s1_valid | out_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_carry  <= '0;
        end else begin
            if (s1_valid && out_adv) begin
                out_sum   <= s1_sum + s1_carry;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Operands are only sampled under in_valid, so undriven inputs never leak forward.
            if (in_valid && s1_adv) begin
                s1_sum   <= csa_sum;
                s1_carry <= {csa_maj[EW-2:0], 1'b0};
                s1_valid <= 1'b1;
            end else if (out_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end
endmodule
